wb_div_initiator: RTL and testbench

Wishbone initiator that drives the serial divider register block from a simple valid/ready command port. A command carries a dividend and divisor. The block performs four single-beat Wishbone accesses:
- write dividend;
- write divisor with start;
- read quotient;
- read remainder.

It then returns the results on a valid/ready response port, with timeout detection for a missing ack.

---
 rtl/wb_div_initiator.sv | 191 +++++++++++++++++++
 tb/tb_wb_div_initiator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_div_initiator.sv
// Wishbone initiator sequencing the serial divider registers:
// write dividend, write divisor+start, read quotient, read remainder.
module wb_div_initiator #(
  parameter int WBW         = 32,
  parameter int XLEN        = 32,
  parameter int WAIT_CYCLES = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [XLEN-1:0]   req_dividend_i,
  input  logic [XLEN-1:0]   req_divisor_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_quotient_o,
  output logic [XLEN-1:0]   rsp_remainder_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [WBW/8-1:0]  wbm_sel_o,
  output logic [WBW-1:0]    wbm_adr_o,
  output logic [WBW-1:0]    wbm_dat_o,
  input  logic [WBW-1:0]    wbm_dat_i,
  input  logic              wbm_ack_i
);

  localparam int CMAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [WBW-1:0] ADR_DVD = WBW'(32'h8000_0000);
  localparam logic [WBW-1:0] ADR_DVS = WBW'(32'h4200_0000);
  localparam logic [WBW-1:0] ADR_QUO = WBW'(32'h2000_0000);
  localparam logic [WBW-1:0] ADR_REM = WBW'(32'h1000_0000);

  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_DVD, S_WR_DVS, S_WAIT,
    S_RD_QUO, S_RD_REM, S_GAP, S_RESP
  } state_e;

  state_e             state_q;
  logic               gap_rd_q;
  logic [CW-1:0]      cnt_q;
  logic [XLEN-1:0]    dvs_q;
  logic [XLEN-1:0]    quo_q;
  logic [XLEN-1:0]    rem_q;
  logic               err_q;
  logic               rsp_valid_q;
  logic               cyc_q;
  logic               we_q;
  logic [WBW/8-1:0]   sel_q;
  logic [WBW-1:0]     adr_q;
  logic [WBW-1:0]     dat_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      gap_rd_q    <= 1'b0;
      cnt_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            dvs_q <= req_divisor_i;
            err_q <= 1'b0;
            cnt_q <= '0;
            if (req_divisor_i == '0) begin
              quo_q       <= '1;
              rem_q       <= req_dividend_i;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              cyc_q   <= 1'b1;
              sel_q   <= '1;
              we_q    <= 1'b1;
              adr_q   <= ADR_DVD;
              dat_q   <= req_dividend_i;
              state_q <= S_WR_DVD;
            end
          end
        end
        S_WR_DVD, S_WR_DVS, S_RD_QUO, S_RD_REM: begin
          if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            cnt_q <= '0;
            unique case (state_q)
              S_WR_DVD: begin
                gap_rd_q <= 1'b0;
                state_q  <= S_GAP;
              end
              S_WR_DVS: state_q <= S_WAIT;
              S_RD_QUO: begin
                quo_q    <= wbm_dat_i;
                gap_rd_q <= 1'b1;
                state_q  <= S_GAP;
              end
              S_RD_REM: begin
                rem_q       <= wbm_dat_i;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RESP;
              end
              default: ;
            endcase
          end else if (cnt_q == TO_LAST) begin
            // ack never came: abandon the access and report
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            err_q       <= 1'b1;
            quo_q       <= '0;
            rem_q       <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          cyc_q <= 1'b1;
          sel_q <= '1;
          cnt_q <= '0;
          if (gap_rd_q) begin
            we_q    <= 1'b0;
            adr_q   <= ADR_REM;
            dat_q   <= '0;
            state_q <= S_RD_REM;
          end else begin
            we_q    <= 1'b1;
            adr_q   <= ADR_DVS;
            dat_q   <= dvs_q;
            state_q <= S_WR_DVS;
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cyc_q   <= 1'b1;
            sel_q   <= '1;
            we_q    <= 1'b0;
            adr_q   <= ADR_QUO;
            dat_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_RD_QUO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_quotient_o  = quo_q;
  assign rsp_remainder_o = rem_q;
  assign rsp_err_o       = err_q;
  assign wbm_cyc_o       = cyc_q;
  assign wbm_stb_o       = cyc_q;
  assign wbm_we_o        = we_q;
  assign wbm_sel_o       = sel_q;
  assign wbm_adr_o       = adr_q;
  assign wbm_dat_o       = dat_q;

endmodule

// File: tb/tb_wb_div_initiator.sv
// Directed bench for wb_div_initiator with a Wishbone divider model
// that has configurable ack delay and an optional missing ack.
module tb_wb_div_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_dvd = '0;
  logic [31:0] req_dvs = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_q, rsp_r;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack_m, ack_inj = 1'b0, ack;
  assign ack = ack_m | ack_inj;

  wb_div_initiator dut (
    .clk_i(clk), .reset_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_dividend_i(req_dvd), .req_divisor_i(req_dvs),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_quotient_o(rsp_q), .rsp_remainder_o(rsp_r),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  // divider register model
  int dly = 0;
  bit noack = 1'b0;
  int wcnt;
  logic [31:0] m_dvd, m_q, m_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0; wcnt <= 0; dat_i <= '0;
      m_dvd <= '0; m_q <= '0; m_r <= '0;
    end else if (ack_m) begin
      ack_m <= 1'b0;
    end else if (stb && !(noack && adr == 32'h4200_0000)) begin
      if (wcnt == dly) begin
        ack_m <= 1'b1;
        wcnt  <= 0;
        if (we && adr == 32'h8000_0000) m_dvd <= dat_o;
        if (we && adr == 32'h4200_0000) begin
          m_q <= m_dvd / dat_o;
          m_r <= m_dvd % dat_o;
        end
        dat_i <= (adr == 32'h2000_0000) ? m_q :
                 (adr == 32'h1000_0000) ? m_r : 32'h0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  // bus monitor
  int acc_n = 0, stb_cnt = 0, viol = 0;
  logic [31:0] log_adr [8];
  logic [31:0] log_dat [8];
  logic        log_we  [8];
  logic        prev_ack = 1'b0;
  always @(negedge clk) begin
    if (stb) stb_cnt++;
    if (stb && ack_m && acc_n < 8) begin
      log_adr[acc_n] = adr;
      log_dat[acc_n] = dat_o;
      log_we[acc_n]  = we;
      acc_n++;
    end
    if (stb !== cyc) viol++;
    if (prev_ack && stb) viol++;
    if (!cyc && (we || sel != 0 || adr != 0 || dat_o != 0)) viol++;
    prev_ack = rst_n ? ack_m : 1'b0;
  end

  int n_pass = 0, n_tot = 0;
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] dvd;
    logic [31:0] dvs;
    int          dly;
    bit          noack;
    logic [31:0] q;
    logic [31:0] r;
    bit          err;
    int          lat;
    int          nacc;
    int          nstb;
    int          hold;
  } vec_t;

  task automatic run_cmd(input vec_t v, input int id);
    int lat;
    int k;
    logic [31:0] q0, r0;
    logic e0;
    logic [31:0] ea [4];
    logic [31:0] ed [4];
    logic        ew [4];
    ea = '{32'h8000_0000, 32'h4200_0000, 32'h2000_0000, 32'h1000_0000};
    ed = '{v.dvd, v.dvs, 32'h0, 32'h0};
    ew = '{1'b1, 1'b1, 1'b0, 1'b0};
    dly = v.dly;
    noack = v.noack;
    rsp_ready = (v.hold == 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_dvd = v.dvd;
    req_dvs = v.dvs;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_accept", id), 32'(k < 50), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_n = 0;
    stb_cnt = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 300);
    chk($sformatf("v%0d_latency", id), lat, v.lat);
    chk($sformatf("v%0d_quotient", id), rsp_q, v.q);
    chk($sformatf("v%0d_remainder", id), rsp_r, v.r);
    chk($sformatf("v%0d_err", id), 32'(rsp_err), 32'(v.err));
    q0 = rsp_q;
    r0 = rsp_r;
    e0 = rsp_err;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_stable%0d", id, i),
          {rsp_valid, rsp_q == q0, rsp_r == r0, rsp_err == e0}, 32'hF);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_idle", id), {rsp_valid, req_ready}, 32'b01);
    chk($sformatf("v%0d_nacc", id), acc_n, v.nacc);
    chk($sformatf("v%0d_nstb", id), stb_cnt, v.nstb);
    for (int i = 0; i < v.nacc; i++) begin
      if (i < acc_n) begin
        chk($sformatf("v%0d_adr%0d", id, i), log_adr[i], ea[i]);
        chk($sformatf("v%0d_we%0d", id, i), 32'(log_we[i]), 32'(ew[i]));
        chk($sformatf("v%0d_dat%0d", id, i), log_dat[i], ed[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vec [7];
  int k, t1, t2, lat;
  logic [31:0] q1, r1;

  initial begin
    //        dvd           dvs   dly na  q             r        e  lat na stb hold
    vec[0] = '{32'd100,     32'd7,   0, 0, 32'd14,      32'd2,   0, 19, 4, 8,  0};
    vec[1] = '{32'h1234,    32'd0,   0, 0, 32'hFFFF_FFFF, 32'h1234, 0, 1, 0, 0, 0};
    vec[2] = '{32'd100,     32'd7,   3, 0, 32'd14,      32'd2,   0, 31, 4, 20, 5};
    vec[3] = '{32'hFFFF_FFFF, 32'd1, 1, 0, 32'hFFFF_FFFF, 32'd0, 0, 23, 4, 12, 0};
    vec[4] = '{32'd7,       32'd100, 0, 0, 32'd0,       32'd7,   0, 19, 4, 8,  2};
    vec[5] = '{32'd100,     32'd7,   0, 1, 32'd0,       32'd0,   1, 20, 1, 18, 0};
    vec[6] = '{32'd50,      32'd5,   0, 0, 32'd10,      32'd0,   0, 19, 4, 8,  0};

    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", {rsp_valid, cyc, stb, we, sel, rsp_err}, 32'd0);
    chk("rst_bus", adr | dat_o | rsp_q | rsp_r, 32'd0);
    #12 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_cmd(vec[i], i);

    // stray ack while idle
    @(negedge clk);
    ack_inj = 1'b1;
    @(negedge clk);
    ack_inj = 1'b0;
    @(negedge clk);
    chk("stray_ack", {req_ready, cyc, rsp_valid}, 32'b100);

    // reset during quotient read
    dly = 0;
    noack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_dvd = 32'd100;
    req_dvs = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    while (!(stb && adr == 32'h2000_0000) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_reach", 32'(k < 100), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", {cyc, stb, we, sel}, 32'd0);
    chk("rst_mid_adr", adr, 32'd0);
    chk("rst_mid_hs", {rsp_valid, req_ready}, 32'b01);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(vec[6], 6);

    // back-to-back with rsp_ready tied high
    dly = 0;
    noack = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_dvd = 32'd50;
    req_dvs = 32'd5;
    @(posedge clk);
    #1;
    req_dvd = 32'd100;
    req_dvs = 32'd7;
    t1 = -1;
    t2 = -1;
    q1 = '0;
    r1 = '0;
    k = 0;
    while (t2 < 0 && k < 100) begin
      @(negedge clk);
      k++;
      if (rsp_valid && t1 < 0) begin
        t1 = k;
        q1 = rsp_q;
        r1 = rsp_r;
      end else if (req_ready && t1 >= 0) begin
        t2 = k;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("b2b_first_lat", t1, 32'd19);
    chk("b2b_first_q", q1, 32'd10);
    chk("b2b_first_r", r1, 32'd0);
    chk("b2b_accept_gap", t2 - t1, 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 300);
    chk("b2b_second_lat", lat, 32'd19);
    chk("b2b_second_q", rsp_q, 32'd14);
    chk("b2b_second_r", rsp_r, 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle", {rsp_valid, req_ready}, 32'b01);

    chk("bus_protocol", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
